// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one pipelined signed multiplier among NREQ requesters.
// Optional busy-cycle counter (busy_cnt, stat_clr) enabled by defining MULT_ARB_STATS_EN.
module mult_share_arbiter #(
  parameter int NREQ      = 4,
  parameter int COEF_SIZE = 25,
  parameter int DATA_SIZE = 25,
  parameter int MULT_LAT  = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NREQ-1:0]                      req,
  input  logic [NREQ*COEF_SIZE-1:0]            op_a,
  input  logic [NREQ*DATA_SIZE-1:0]            op_b,
  output logic [NREQ-1:0]                      gnt,
  output logic signed [COEF_SIZE+DATA_SIZE-1:0] prod,
`ifdef MULT_ARB_STATS_EN
  input  logic                                 stat_clr,
  output logic [15:0]                          busy_cnt,
`endif
  output logic [NREQ-1:0]                      prod_valid
);

  localparam int PW        = COEF_SIZE + DATA_SIZE;
  localparam int PTR_W     = $clog2(NREQ);
  localparam int TAG_DEPTH = 1 + MULT_LAT;

  logic [PTR_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]            gnt_idx;
  logic [NREQ-1:0]             gnt_raw;
  logic                        any_gnt;
  int                          cand;
  logic signed [COEF_SIZE-1:0] a_q, a_d;
  logic signed [DATA_SIZE-1:0] b_q, b_d;
  logic signed [PW-1:0]        mult_res;
  logic [NREQ-1:0]             tag_q [TAG_DEPTH];
  logic [NREQ-1:0]             tag_d [TAG_DEPTH];

  // Search from rr_ptr with wrap; the first requester found wins and its operands are captured.
  always_comb begin
    gnt_raw  = '0;
    any_gnt  = 1'b0;
    gnt_idx  = '0;
    cand     = 0;
    a_d      = '0;
    b_d      = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = int'(rr_ptr_q) + off;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!any_gnt && req[cand]) begin
        any_gnt       = 1'b1;
        gnt_raw[cand] = 1'b1;
        gnt_idx       = PTR_W'(cand);
        a_d           = op_a[cand*COEF_SIZE +: COEF_SIZE];
        b_d           = op_b[cand*DATA_SIZE +: DATA_SIZE];
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (any_gnt) begin
      rr_ptr_d = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  assign gnt = reset ? gnt_raw : '0;

  always_comb begin
    tag_d[0] = gnt;
    for (int i = 1; i < TAG_DEPTH; i++) tag_d[i] = tag_q[i-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_q[i] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      for (int i = 0; i < TAG_DEPTH; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign prod_valid = tag_q[TAG_DEPTH-1];

  // Stand-in for mult_gen_0: full-width signed product followed by MULT_LAT unreset stages.
  assign mult_res = PW'(a_q) * PW'(b_q);

  if (MULT_LAT == 0) begin : g_comb
    assign prod = mult_res;
  end else begin : g_pipe
    logic signed [PW-1:0] pipe_q [MULT_LAT];
    logic signed [PW-1:0] pipe_d [MULT_LAT];

    always_comb begin
      pipe_d[0] = mult_res;
      for (int i = 1; i < MULT_LAT; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk) begin
      for (int i = 0; i < MULT_LAT; i++) pipe_q[i] <= pipe_d[i];
    end

    assign prod = pipe_q[MULT_LAT-1];
  end

`ifdef MULT_ARB_STATS_EN
  logic [15:0] busy_cnt_q, busy_cnt_d;

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (stat_clr) busy_cnt_d = '0;
    else if (any_gnt && busy_cnt_q != 16'hFFFF) busy_cnt_d = busy_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_cnt_q <= '0;
    else        busy_cnt_q <= busy_cnt_d;
  end

  assign busy_cnt = busy_cnt_q;
`endif

endmodule
